pc_gen: RTL and testbench

- Parametrised successor to the combinational next-PC selector: owns the architectural fetch PC register and its redirect priority, and drives a valid/ready fetch-request handshake toward the instruction-fetch port.
- Sits at the head of IF. Redirect sources are exception entry, ertn return and EX-stage branch/jump. Pipeline stall comes from hazard control.
- Adds a pending-redirect buffer: a redirect that arrives while a fetch request is stuck un-accepted is held, never lost.

---
 rtl/pc_gen_if.sv | 23 ++
 rtl/pc_gen.sv | 145 ++++++++++++++
 tb/tb_pc_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-request handshake between the PC generator (master) and the instruction-fetch port (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic            fetch_stale;

    modport master (
        output fetch_valid,
        output pc,
        output fetch_stale,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        input  fetch_stale,
        output fetch_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC register with EXC > ERTN > BR redirect priority and a pending-redirect buffer.
// Optional misaligned-target check enabled by defining PC_ALIGN_CHK_EN (adds fetch_adef).
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h1C00_0000,
    parameter int              INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            exc_sig,
    input  logic [XLEN-1:0] eentry,
    input  logic            ertn_sig,
    input  logic [XLEN-1:0] era,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            redirect_pending,
`ifdef PC_ALIGN_CHK_EN
    output logic            fetch_adef,
`endif
    pc_gen_if.master        fetch
);

    // Encoding order doubles as priority order for the compare below.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_BR   = 2'd1,
        CLS_ERTN = 2'd2,
        CLS_EXC  = 2'd3
    } redir_cls_e;

    logic            run_q, run_d;
    logic            hold_q, hold_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_valid_q, pend_valid_d;
    redir_cls_e      pend_class_q, pend_class_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            adef_q, adef_d;

    redir_cls_e      live_cls;
    logic [XLEN-1:0] live_addr;
    redir_cls_e      req_cls;
    logic [XLEN-1:0] req_addr;
    logic            req_valid;
    logic            fetch_valid;
    logic            hs;
    logic            pc_load;
    logic [XLEN-1:0] pc_inc;

    always_comb begin
        live_cls  = CLS_NONE;
        live_addr = '0;
        if (exc_sig) begin
            live_cls  = CLS_EXC;
            live_addr = eentry;
        end else if (ertn_sig) begin
            live_cls  = CLS_ERTN;
            live_addr = era;
        end else if (br_taken) begin
            live_cls  = CLS_BR;
            live_addr = br_target;
        end
    end

    // Equal class lets the newer live request replace the buffered one.
    always_comb begin
        req_cls  = pend_class_q;
        req_addr = pend_addr_q;
        if (live_cls >= pend_class_q) begin
            req_cls  = live_cls;
            req_addr = live_addr;
        end
    end

    assign req_valid = (req_cls != CLS_NONE);
    assign pc_inc    = pc_q + XLEN'(INST_BYTES);

`ifdef PC_ALIGN_CHK_EN
    assign fetch_valid = run_q & (~stall | hold_q) & ~adef_q;
    assign fetch_adef  = adef_q;
`else
    assign fetch_valid = run_q & (~stall | hold_q);
`endif

    assign hs = fetch_valid & fetch.fetch_ready;

    always_comb begin
        run_d        = 1'b1;
        hold_d       = fetch_valid & ~fetch.fetch_ready;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_class_d = pend_class_q;
        pend_addr_d  = pend_addr_q;
        pc_load      = 1'b0;
        if (hold_q && !hs) begin
            pend_valid_d = req_valid;
            pend_class_d = req_cls;
            pend_addr_d  = req_addr;
        end else begin
            pend_valid_d = 1'b0;
            pend_class_d = CLS_NONE;
            pend_addr_d  = '0;
            if (req_valid) begin
                pc_d    = req_addr;
                pc_load = 1'b1;
            end else if (hs && !stall) begin
                pc_d    = pc_inc;
                pc_load = 1'b1;
            end
        end
        adef_d = pc_load ? (pc_d[1:0] != 2'b00) : adef_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q        <= 1'b0;
            hold_q       <= 1'b0;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_class_q <= CLS_NONE;
            pend_addr_q  <= '0;
            adef_q       <= 1'b0;
        end else begin
            run_q        <= run_d;
            hold_q       <= hold_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_class_q <= pend_class_d;
            pend_addr_q  <= pend_addr_d;
            adef_q       <= adef_d;
        end
    end

    assign fetch.fetch_valid = fetch_valid;
    assign fetch.pc          = pc_q;
    assign fetch.fetch_stale = hold_q & hs & req_valid;
    assign redirect_pending  = pend_valid_q;

`ifndef PC_ALIGN_CHK_EN
    // Alignment tracking has no consumer in this build.
    logic unused_adef;
    assign unused_adef = adef_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; exercises the PC_ALIGN_CHK_EN path when defined.
module tb_pc_gen;
    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        exc_sig = 1'b0;
    logic [31:0] eentry = '0;
    logic        ertn_sig = 1'b0;
    logic [31:0] era = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        redirect_pending;
`ifdef PC_ALIGN_CHK_EN
    logic        fetch_adef;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    pc_gen_if #(.XLEN(32)) fif ();

    pc_gen #(.XLEN(32), .RESET_PC(32'h1C00_0000), .INST_BYTES(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall            (stall),
        .exc_sig          (exc_sig),
        .eentry           (eentry),
        .ertn_sig         (ertn_sig),
        .era              (era),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .redirect_pending (redirect_pending),
`ifdef PC_ALIGN_CHK_EN
        .fetch_adef       (fetch_adef),
`endif
        .fetch            (fif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_req();
        exc_sig = 1'b0; ertn_sig = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_reset();
        fif.fetch_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (fif.pc !== RST_PC) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", fif.pc, RST_PC); end
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", fif.fetch_valid); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_bad++; $display("FAIL rst_pend got=%b exp=0", redirect_pending); end
        n_cmp++; if (fif.fetch_stale !== 1'b0) begin n_bad++; $display("FAIL rst_stale got=%b exp=0", fif.fetch_stale); end
        rstn = 1'b1;
        #1;
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rel_valid got=%b exp=0", fif.fetch_valid); end
        $display("test_reset done pc=%h", fif.pc);
    endtask

    task automatic test_sequential();
        step();
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid got=%b exp=1", fif.fetch_valid); end
        n_cmp++; if (fif.pc !== 32'h1C00_0000) begin n_bad++; $display("FAIL seq_pc0 got=%h exp=1c000000", fif.pc); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0004) begin n_bad++; $display("FAIL seq_pc1 got=%h exp=1c000004", fif.pc); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0008) begin n_bad++; $display("FAIL seq_pc2 got=%h exp=1c000008", fif.pc); end
        $display("test_sequential done pc=%h", fif.pc);
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_target = 32'h1C00_0100;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_0100) begin n_bad++; $display("FAIL br_pc got=%h exp=1c000100", fif.pc); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_bad++; $display("FAIL br_pend got=%b exp=0", redirect_pending); end
        $display("test_branch done pc=%h", fif.pc);
    endtask

    task automatic test_hold_stale();
        fif.fetch_ready = 1'b0;
        step();
        br_taken = 1'b1; br_target = 32'h1C00_0200;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_0100) begin n_bad++; $display("FAIL hold_pc got=%h exp=1c000100", fif.pc); end
        n_cmp++; if (redirect_pending !== 1'b1) begin n_bad++; $display("FAIL hold_pend got=%b exp=1", redirect_pending); end
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got=%b exp=1", fif.fetch_valid); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0100) begin n_bad++; $display("FAIL hold_pc2 got=%h exp=1c000100", fif.pc); end
        fif.fetch_ready = 1'b1;
        #1;
        n_cmp++; if (fif.fetch_stale !== 1'b1) begin n_bad++; $display("FAIL hold_stale got=%b exp=1", fif.fetch_stale); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0200) begin n_bad++; $display("FAIL hold_tgt got=%h exp=1c000200", fif.pc); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_bad++; $display("FAIL hold_clr got=%b exp=0", redirect_pending); end
        n_cmp++; if (fif.fetch_stale !== 1'b0) begin n_bad++; $display("FAIL hold_stale_clr got=%b exp=0", fif.fetch_stale); end
        $display("test_hold_stale done pc=%h", fif.pc);
    endtask

    task automatic test_priority();
        exc_sig = 1'b1; eentry = 32'h1C00_8000;
        ertn_sig = 1'b1; era = 32'h1C00_A000;
        br_taken = 1'b1; br_target = 32'h1C00_0400;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_8000) begin n_bad++; $display("FAIL prio_pc got=%h exp=1c008000", fif.pc); end
        ertn_sig = 1'b1; br_taken = 1'b1;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_A000) begin n_bad++; $display("FAIL prio_ertn got=%h exp=1c00a000", fif.pc); end
        exc_sig = 1'b1;
        step(); clear_req();
        $display("test_priority done pc=%h", fif.pc);
    endtask

    task automatic test_pend_exc();
        fif.fetch_ready = 1'b0;
        step();
        exc_sig = 1'b1; eentry = 32'h1C00_8000;
        step(); clear_req();
        n_cmp++; if (redirect_pending !== 1'b1) begin n_bad++; $display("FAIL pexc_pend got=%b exp=1", redirect_pending); end
        br_taken = 1'b1; br_target = 32'h1C00_0300;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_8000) begin n_bad++; $display("FAIL pexc_pc got=%h exp=1c008000", fif.pc); end
        fif.fetch_ready = 1'b1;
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_8000) begin n_bad++; $display("FAIL pexc_tgt got=%h exp=1c008000", fif.pc); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_bad++; $display("FAIL pexc_clr got=%b exp=0", redirect_pending); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_8004) begin n_bad++; $display("FAIL pexc_inc got=%h exp=1c008004", fif.pc); end
        $display("test_pend_exc done pc=%h", fif.pc);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid got=%b exp=0", fif.fetch_valid); end
        step(); step();
        n_cmp++; if (fif.pc !== 32'h1C00_8004) begin n_bad++; $display("FAIL stall_pc got=%h exp=1c008004", fif.pc); end
        stall = 1'b0;
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_8008) begin n_bad++; $display("FAIL stall_rel got=%h exp=1c008008", fif.pc); end
        fif.fetch_ready = 1'b0;
        step();
        stall = 1'b1;
        #1;
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL stallh_valid got=%b exp=1", fif.fetch_valid); end
        step();
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL stallh_valid2 got=%b exp=1", fif.fetch_valid); end
        fif.fetch_ready = 1'b1;
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_8008) begin n_bad++; $display("FAIL stallh_pc got=%h exp=1c008008", fif.pc); end
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL stallh_drop got=%b exp=0", fif.fetch_valid); end
        br_taken = 1'b1; br_target = 32'h1C00_0900;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_0900) begin n_bad++; $display("FAIL stall_redir got=%h exp=1c000900", fif.pc); end
        stall = 1'b0;
        $display("test_stall done pc=%h", fif.pc);
    endtask

    task automatic test_replace();
        fif.fetch_ready = 1'b0;
        step();
        br_taken = 1'b1; br_target = 32'h1C00_0600;
        step();
        br_target = 32'h1C00_0700;
        step(); clear_req();
        fif.fetch_ready = 1'b1;
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0700) begin n_bad++; $display("FAIL repl_pc got=%h exp=1c000700", fif.pc); end
        $display("test_replace done pc=%h", fif.pc);
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
        step(); clear_req();
        step();
        n_cmp++; if (fif.pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_fc got=%h exp=fffffffc", fif.pc); end
        step();
        n_cmp++; if (fif.pc !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_zero got=%h exp=00000000", fif.pc); end
        $display("test_wrap done pc=%h", fif.pc);
    endtask

    task automatic test_align();
        br_taken = 1'b1; br_target = 32'h1C00_0102;
        step(); clear_req();
        n_cmp++; if (fif.pc !== 32'h1C00_0102) begin n_bad++; $display("FAIL algn_pc got=%h exp=1c000102", fif.pc); end
`ifdef PC_ALIGN_CHK_EN
        n_cmp++; if (fetch_adef !== 1'b1) begin n_bad++; $display("FAIL algn_adef got=%b exp=1", fetch_adef); end
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL algn_valid got=%b exp=0", fif.fetch_valid); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0102) begin n_bad++; $display("FAIL algn_hold got=%h exp=1c000102", fif.pc); end
        exc_sig = 1'b1; eentry = 32'h1C00_8000;
        step(); clear_req();
        n_cmp++; if (fetch_adef !== 1'b0) begin n_bad++; $display("FAIL algn_clr got=%b exp=0", fetch_adef); end
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL algn_revalid got=%b exp=1", fif.fetch_valid); end
`else
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL algn_valid got=%b exp=1", fif.fetch_valid); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0106) begin n_bad++; $display("FAIL algn_inc got=%h exp=1c000106", fif.pc); end
`endif
        $display("test_align done pc=%h", fif.pc);
    endtask

    task automatic test_reset_mid();
        fif.fetch_ready = 1'b0;
        step();
        br_taken = 1'b1; br_target = 32'h1C00_0A00;
        step(); clear_req();
        n_cmp++; if (redirect_pending !== 1'b1) begin n_bad++; $display("FAIL rmid_pend got=%b exp=1", redirect_pending); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (fif.pc !== RST_PC) begin n_bad++; $display("FAIL rmid_pc got=%h exp=%h", fif.pc, RST_PC); end
        n_cmp++; if (redirect_pending !== 1'b0) begin n_bad++; $display("FAIL rmid_clr got=%b exp=0", redirect_pending); end
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b exp=0", fif.fetch_valid); end
        @(negedge clk);
        rstn = 1'b1; fif.fetch_ready = 1'b1;
        step();
        n_cmp++; if (fif.pc !== RST_PC) begin n_bad++; $display("FAIL rmid_pc2 got=%h exp=%h", fif.pc, RST_PC); end
        step();
        n_cmp++; if (fif.pc !== 32'h1C00_0004) begin n_bad++; $display("FAIL rmid_inc got=%h exp=1c000004", fif.pc); end
        $display("test_reset_mid done pc=%h", fif.pc);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_hold_stale();
        test_priority();
        test_pend_exc();
        test_stall();
        test_replace();
        test_wrap();
        test_align();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
